wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares one scoreboard write-back port among `NR_REQ` functional units that do not each own a dedicated port. Each requester feeds a small per-requester FIFO, and a round-robin scheduler drains the FIFO heads onto a registered write-back port. That port drives one lane of the scoreboard's `trans_id_i`/`wbdata_i`/`ex_i`/`wt_valid_i` bundle. The block sits between the execute-stage units and the issue stage and absorbs result collisions, so the units need no mutual stall logic.

## Interface
- `NR_REQ`, default 3: number of requesting functional units (2..8).
- `DEPTH`, default 2: entries per requester FIFO (power of two, ≥2).
- `TRANS_ID_BITS`, default `ariane_pkg::TRANS_ID_BITS`: scoreboard transaction-ID width.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous reset, active low.
- `flush_i`  in  1  pipeline flush; discards all buffered results.
- `valid_i`  in  NR_REQ  per-requester result valid.
- `ready_o`  out  NR_REQ  per-requester FIFO not full.
- `trans_id_i`  in  NR_REQ×TRANS_ID_BITS  result transaction ID.
- `data_i`  in  NR_REQ×riscv::XLEN  result data.
- `ex_valid_i`  in  NR_REQ  result carries an exception; `data_i` holds the cause.
- `wt_valid_o`  out  1  write-back valid to the scoreboard.
- `trans_id_o`  out  TRANS_ID_BITS  write-back transaction ID.
- `wbdata_o`  out  riscv::XLEN  write-back data.
- `ex_valid_o`  out  1  write-back exception flag.
- `grant_o`  out  NR_REQ  one-hot source of the current `wt_valid_o` beat.
- `conflict_cnt_o`  out  32  contention counter (see Configuration).

## Operation
- **Push.** Requester i pushes when `valid_i[i] && ready_o[i]`.
  - `ready_o[i] = (count[i] != DEPTH)`, computed from registered count only. A same-cycle pop does not raise it.
  - A `valid_i` that arrives while not ready is ignored. Requesters must hold `valid_i` until they see ready.
- **Arbitration.** Each cycle the scheduler selects one non-empty FIFO head, round-robin.
  - The search starts at `rr_ptr`. After a grant to i, `rr_ptr <= (i+1) mod NR_REQ`.
  - When no FIFO is non-empty, `rr_ptr` holds.
- **Pop and output.** The selected head is popped, and its fields load the output register at the same edge. The output port has no back-pressure; the scoreboard accepts every beat.
- **FIFO count.** Push and pop on the same FIFO in the same cycle leave the count unchanged, and that data ordering is preserved. Pointers wrap modulo `DEPTH`.
- **Flush.** While `flush_i` is high:
  - all counts and read/write pointers go to 0 at the next edge;
  - pushes that cycle are dropped;
  - `wt_valid_o` is 0 the following cycle;
  - `rr_ptr` is not reset.
- **Reset values.** `wt_valid_o`=0, `trans_id_o`=0, `wbdata_o`=0, `ex_valid_o`=0, `grant_o`=0, `conflict_cnt_o`=0, `rr_ptr`=0, all FIFOs empty (`ready_o` all 1 once reset deasserts).
- **Reset mid-operation.** Asynchronous assertion clears all state immediately. Buffered results are lost.
- **Idle data path.** When `wt_valid_o` is 0, the data outputs hold their last value, and `grant_o` is 0.

## Timing
- **Latency.** A result accepted at edge E appears on `wt_valid_o` in the cycle after edge E+1, when uncontended. There is no input-to-output combinational path.
- **Throughput.** One write-back per cycle in aggregate. Per requester, sustained one per cycle when alone, because the `DEPTH`≥2 FIFO covers the registered ready.
- **Worst-case wait.** With all FIFOs non-empty, a head waits at most `NR_REQ-1` grants.
- **Output pulse.** `wt_valid_o` is a single-cycle pulse per result. Back-to-back pulses are allowed.

## Configuration
- `WB_ARB_PERF_EN` defined:
  - `conflict_cnt_o` increments by 1 each cycle in which ≥2 FIFOs are non-empty;
  - it saturates at 2^32-1;
  - it is cleared only by reset, not by flush.
- Not defined: `conflict_cnt_o` is tied to 0, and no counter logic is synthesized.

## Test plan
- **Single requester.** Reset, then `valid_i`=3'b001 with trans_id 5 and data 0xDEAD for one cycle → `wt_valid_o`=1 with trans_id 5, data 0xDEAD and `grant_o`=3'b001 exactly two edges after acceptance; no other beats.
- **Round-robin.** All three requesters push one result (IDs 1, 2, 3) in the same cycle from `rr_ptr`=0 → outputs in consecutive cycles with IDs 1, 2, 3; afterwards `rr_ptr`=0.
- **Full FIFO.** Requester 1 pushes every cycle while requesters 0 and 2 also stream → `ready_o[1]` drops when count reaches 2; no result lost or duplicated; per-requester ID order preserved.
- **Flush.** Fill all FIFOs, then assert `flush_i` for 1 cycle with a concurrent push → no `wt_valid_o` after the flush edge+1; the concurrent push never appears; `ready_o`=3'b111.
- **Exception pass-through.** Push with `ex_valid_i`=1 and data=cause 2 → `ex_valid_o`=1 and `wbdata_o`=2 on the beat.
- **Perf counter.** With `WB_ARB_PERF_EN` defined, hold two FIFOs non-empty for 4 cycles → `conflict_cnt_o`=4. Without the macro → `conflict_cnt_o`=0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares one scoreboard write-back lane among NR_REQ functional units.
//   Each requester feeds its own small FIFO; a round-robin scheduler pops
//   one non-empty head per cycle into a registered write-back port, so the
//   units never have to stall on one another.
//
// Optional feature:
//   WB_ARB_PERF_EN - when defined, conflict_cnt_o counts cycles in which two
//                    or more FIFOs are non-empty (saturating, reset-only
//                    clear). When undefined the output is tied to 0.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   flush_i            discard all buffered results
//   valid_i/ready_o    per-requester push handshake (ready from registered count)
//   trans_id_i, data_i, ex_valid_i   per-requester result fields
//   wt_valid_o, trans_id_o, wbdata_o, ex_valid_o   registered write-back beat
//   grant_o            one-hot source of the current beat (0 when idle)
//   conflict_cnt_o     contention counter (see above)

module wb_port_arbiter #(
  parameter int unsigned NR_REQ        = 3,
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned XLEN          = 64
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     flush_i,
  input  logic [NR_REQ-1:0]                        valid_i,
  output logic [NR_REQ-1:0]                        ready_o,
  input  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0]     trans_id_i,
  input  logic [NR_REQ-1:0][XLEN-1:0]              data_i,
  input  logic [NR_REQ-1:0]                        ex_valid_i,
  output logic                                     wt_valid_o,
  output logic [TRANS_ID_BITS-1:0]                 trans_id_o,
  output logic [XLEN-1:0]                          wbdata_o,
  output logic                                     ex_valid_o,
  output logic [NR_REQ-1:0]                        grant_o,
  output logic [31:0]                              conflict_cnt_o
);

  localparam int unsigned PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  // FIFO storage (no reset needed: validity is tracked by cnt)
  logic [TRANS_ID_BITS-1:0] mem_tid  [NR_REQ][DEPTH];
  logic [XLEN-1:0]          mem_data [NR_REQ][DEPTH];
  logic                     mem_ex   [NR_REQ][DEPTH];

  logic [AW-1:0] wr_ptr [NR_REQ];
  logic [AW-1:0] rd_ptr [NR_REQ];
  logic [AW:0]   cnt    [NR_REQ];

  logic [NR_REQ-1:0] ready;
  logic [NR_REQ-1:0] not_empty;
  logic [NR_REQ-1:0] push;
  logic [NR_REQ-1:0] pop;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_next;
  logic [PTR_W-1:0] sel;
  logic [PTR_W-1:0] sel_hi;
  logic [PTR_W-1:0] sel_lo;
  logic             found_hi;
  logic             any_req;

  logic [TRANS_ID_BITS-1:0] head_tid;
  logic [XLEN-1:0]          head_data;
  logic                     head_ex;

  // Status derived from registered counts only; a same-cycle pop does not
  // raise ready, which keeps the ready path free of the arbiter.
  always_comb begin
    ready     = '0;
    not_empty = '0;
    push      = '0;
    for (int i = 0; i < int'(NR_REQ); i++) begin
      ready[i]     = (cnt[i] != CNT_FULL);
      not_empty[i] = (cnt[i] != '0);
      push[i]      = valid_i[i] && ready[i] && !flush_i;
    end
  end

  assign ready_o = ready;

  // Round-robin pick: lowest non-empty index at or above rr_ptr, otherwise
  // wrap to the lowest non-empty index overall. Scanning downward makes the
  // last assignment the smallest matching index.
  always_comb begin
    sel_hi   = '0;
    sel_lo   = '0;
    found_hi = 1'b0;
    for (int i = int'(NR_REQ) - 1; i >= 0; i--) begin
      if (not_empty[i]) begin
        sel_lo = PTR_W'(i);
        if (PTR_W'(i) >= rr_ptr) begin
          sel_hi   = PTR_W'(i);
          found_hi = 1'b1;
        end
      end
    end
    sel     = found_hi ? sel_hi : sel_lo;
    any_req = |not_empty;
    rr_next = (sel == PTR_W'(NR_REQ - 1)) ? '0 : sel + 1'b1;

    pop       = '0;
    head_tid  = '0;
    head_data = '0;
    head_ex   = 1'b0;
    for (int i = 0; i < int'(NR_REQ); i++) begin
      if (sel == PTR_W'(i)) begin
        pop[i]    = any_req && !flush_i;
        head_tid  = mem_tid[i][rd_ptr[i]];
        head_data = mem_data[i][rd_ptr[i]];
        head_ex   = mem_ex[i][rd_ptr[i]];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(NR_REQ); i++) begin
      if (push[i]) begin
        mem_tid[i][wr_ptr[i]]  <= trans_id_i[i];
        mem_data[i][wr_ptr[i]] <= data_i[i];
        mem_ex[i][wr_ptr[i]]   <= ex_valid_i[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NR_REQ); i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < int'(NR_REQ); i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NR_REQ); i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Write-back register. Data fields hold while idle; rr_ptr only moves on
  // a grant and survives a flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      wt_valid_o <= 1'b0;
      trans_id_o <= '0;
      wbdata_o   <= '0;
      ex_valid_o <= 1'b0;
      grant_o    <= '0;
    end else if (flush_i) begin
      wt_valid_o <= 1'b0;
      grant_o    <= '0;
    end else if (any_req) begin
      wt_valid_o <= 1'b1;
      trans_id_o <= head_tid;
      wbdata_o   <= head_data;
      ex_valid_o <= head_ex;
      grant_o    <= pop;
      rr_ptr     <= rr_next;
    end else begin
      wt_valid_o <= 1'b0;
      grant_o    <= '0;
    end
  end

`ifdef WB_ARB_PERF_EN
  logic [31:0] conflict_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_cnt_q <= '0;
    end else if (($countones(not_empty) >= 2) && (conflict_cnt_q != '1)) begin
      conflict_cnt_q <= conflict_cnt_q + 1'b1;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;
`else
  assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int NR = 3;
  localparam int TW = 8;
  localparam int XW = 64;

`ifdef WB_ARB_PERF_EN
  localparam logic [31:0] EXP_C2 = 32'd2;
  localparam logic [31:0] EXP_C4 = 32'd4;
`else
  localparam logic [31:0] EXP_C2 = 32'd0;
  localparam logic [31:0] EXP_C4 = 32'd0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   flush = 1'b0;
  logic [NR-1:0]          valid = '0;
  logic [NR-1:0]          ex_valid = '0;
  logic [NR-1:0][TW-1:0]  tid = '0;
  logic [NR-1:0][XW-1:0]  data = '0;
  logic [NR-1:0]          ready;
  logic                   wt_valid;
  logic [TW-1:0]          tid_o;
  logic [XW-1:0]          wbdata;
  logic                   ex_o;
  logic [NR-1:0]          grant;
  logic [31:0]            conflict_cnt;

  int total = 0;
  int bad = 0;

  wb_port_arbiter #(
    .NR_REQ(NR), .DEPTH(2), .TRANS_ID_BITS(TW), .XLEN(XW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .valid_i(valid), .ready_o(ready), .trans_id_i(tid), .data_i(data),
    .ex_valid_i(ex_valid), .wt_valid_o(wt_valid), .trans_id_o(tid_o),
    .wbdata_o(wbdata), .ex_valid_o(ex_o), .grant_o(grant),
    .conflict_cnt_o(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid = '0; ex_valid = '0; tid = '0; data = '0; flush = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({wt_valid, grant, ex_o} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b expected 00000", {wt_valid, grant, ex_o});
    end
    total++;
    if ({tid_o, wbdata} !== '0) begin
      bad++; $display("FAIL reset_data: got %h/%h expected 0/0", tid_o, wbdata);
    end
    total++;
    if (conflict_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_cnt: got %0d expected 0", conflict_cnt);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (ready !== 3'b111 || wt_valid !== 1'b0) begin
      bad++; $display("FAIL reset_ready: got ready=%b wt=%b expected 111/0", ready, wt_valid);
    end
  endtask

  task automatic test_single();
    int beats;
    valid = 3'b001; tid[0] = 8'd5; data[0] = 64'hDEAD;
    tick();
    clear_inputs();
    total++;
    if (wt_valid !== 1'b0) begin
      bad++; $display("FAIL single_early: got wt=%b expected 0", wt_valid);
    end
    tick();
    total++;
    if ({wt_valid, grant, tid_o, ex_o} !== {1'b1, 3'b001, 8'd5, 1'b0}) begin
      bad++; $display("FAIL single_beat: got wt=%b g=%b id=%0d ex=%b expected 1/001/5/0",
                      wt_valid, grant, tid_o, ex_o);
    end
    total++;
    if (wbdata !== 64'hDEAD) begin
      bad++; $display("FAIL single_data: got %h expected dead", wbdata);
    end
    beats = 0;
    repeat (4) begin
      tick();
      if (wt_valid) beats++;
    end
    total++;
    if (beats !== 0) begin
      bad++; $display("FAIL single_extra: got %0d beats expected 0", beats);
    end
    total++;
    if (grant !== 3'b000 || wbdata !== 64'hDEAD) begin
      bad++; $display("FAIL single_idle: got g=%b d=%h expected 000/dead", grant, wbdata);
    end
  endtask

  task automatic test_reset_mid();
    int beats;
    valid = 3'b111; tid = {8'h13, 8'h12, 8'h11}; data = {64'h3, 64'h2, 64'h1};
    tick();
    clear_inputs();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({wt_valid, grant, tid_o} !== '0 || wbdata !== '0 || ready !== 3'b111) begin
      bad++; $display("FAIL reset_mid: got wt=%b g=%b id=%h d=%h rdy=%b expected 0/0/0/0/111",
                      wt_valid, grant, tid_o, wbdata, ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    beats = 0;
    repeat (5) begin
      tick();
      if (wt_valid) beats++;
    end
    total++;
    if (beats !== 0) begin
      bad++; $display("FAIL reset_mid_lost: got %0d beats expected 0", beats);
    end
  endtask

  task automatic test_round_robin();
    valid = 3'b111; tid = {8'd3, 8'd2, 8'd1}; data = {64'd300, 64'd200, 64'd100};
    tick();
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({wt_valid, grant, tid_o} !== {1'b1, 3'(1 << k), 8'(k + 1)} || wbdata !== 64'((k + 1) * 100)) begin
        bad++; $display("FAIL rr_order%0d: got wt=%b g=%b id=%0d d=%0d expected 1/%b/%0d/%0d",
                        k, wt_valid, grant, tid_o, wbdata, 3'(1 << k), k + 1, (k + 1) * 100);
      end
    end
    tick();
    total++;
    if (wt_valid !== 1'b0) begin
      bad++; $display("FAIL rr_done: got wt=%b expected 0", wt_valid);
    end
    // rr_ptr back at 0: requester 1 must win over requester 2
    valid = 3'b110; tid[1] = 8'd4; tid[2] = 8'd6;
    tick();
    clear_inputs();
    tick();
    total++;
    if ({grant, tid_o} !== {3'b010, 8'd4}) begin
      bad++; $display("FAIL rr_ptr_first: got g=%b id=%0d expected 010/4", grant, tid_o);
    end
    tick();
    total++;
    if ({grant, tid_o} !== {3'b100, 8'd6}) begin
      bad++; $display("FAIL rr_ptr_second: got g=%b id=%0d expected 100/6", grant, tid_o);
    end
    tick();
  endtask

  task automatic test_exception();
    valid = 3'b010; tid[1] = 8'd7; data[1] = 64'd2; ex_valid = 3'b010;
    tick();
    clear_inputs();
    tick();
    total++;
    if ({wt_valid, ex_o, grant, tid_o} !== {1'b1, 1'b1, 3'b010, 8'd7} || wbdata !== 64'd2) begin
      bad++; $display("FAIL exception: got wt=%b ex=%b g=%b id=%0d d=%0d expected 1/1/010/7/2",
                      wt_valid, ex_o, grant, tid_o, wbdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      total++;
      if (ready[2] !== 1'b1) begin
        bad++; $display("FAIL b2b_ready%0d: got %b expected 1", k, ready[2]);
      end
      valid = 3'b100; tid[2] = 8'(8'h40 + k);
      tick();
      if (k > 0) begin
        total++;
        if ({wt_valid, grant, tid_o} !== {1'b1, 3'b100, 8'(8'h40 + k - 1)}) begin
          bad++; $display("FAIL b2b_beat%0d: got wt=%b g=%b id=%h expected 1/100/%h",
                          k - 1, wt_valid, grant, tid_o, 8'(8'h40 + k - 1));
        end
      end
    end
    clear_inputs();
    tick();
    total++;
    if ({wt_valid, tid_o} !== {1'b1, 8'h43}) begin
      bad++; $display("FAIL b2b_last: got wt=%b id=%h expected 1/43", wt_valid, tid_o);
    end
    tick();
    total++;
    if (wt_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_end: got wt=%b expected 0", wt_valid);
    end
  endtask

  task automatic test_flush();
    int beats;
    valid = 3'b111; tid = {8'h22, 8'h21, 8'h20};
    tick();
    tid = {8'h25, 8'h24, 8'h23};
    tick();
    total++;
    if ({wt_valid, grant, tid_o} !== {1'b1, 3'b001, 8'h20}) begin
      bad++; $display("FAIL flush_pre: got wt=%b g=%b id=%h expected 1/001/20", wt_valid, grant, tid_o);
    end
    flush = 1'b1; tid = {8'h72, 8'h71, 8'h70};
    tick();
    clear_inputs();
    total++;
    if ({wt_valid, grant, ready} !== {1'b0, 3'b000, 3'b111}) begin
      bad++; $display("FAIL flush_state: got wt=%b g=%b rdy=%b expected 0/000/111", wt_valid, grant, ready);
    end
    beats = 0;
    repeat (4) begin
      tick();
      if (wt_valid) beats++;
    end
    total++;
    if (beats !== 0) begin
      bad++; $display("FAIL flush_leak: got %0d beats expected 0", beats);
    end
    // rr_ptr survived the flush at 1
    valid = 3'b111; tid = {8'h32, 8'h31, 8'h30};
    tick();
    clear_inputs();
    tick();
    total++;
    if ({grant, tid_o} !== {3'b010, 8'h31}) begin
      bad++; $display("FAIL flush_rr1: got g=%b id=%h expected 010/31", grant, tid_o);
    end
    tick();
    total++;
    if ({grant, tid_o} !== {3'b100, 8'h32}) begin
      bad++; $display("FAIL flush_rr2: got g=%b id=%h expected 100/32", grant, tid_o);
    end
    tick();
    total++;
    if ({grant, tid_o} !== {3'b001, 8'h30}) begin
      bad++; $display("FAIL flush_rr3: got g=%b id=%h expected 001/30", grant, tid_o);
    end
    tick();
  endtask

  task automatic test_full_fifo();
    int sent[NR];
    int cnt_m[NR];
    logic [TW-1:0] got[NR][$];
    logic [NR-1:0] rdy;
    bit saw_full;
    int nbeats;
    int cyc;
    saw_full = 1'b0; nbeats = 0; cyc = 0;
    for (int r = 0; r < NR; r++) begin
      sent[r] = 0; cnt_m[r] = 0;
    end
    while ((sent[0] < 6 || sent[1] < 6 || sent[2] < 6 || nbeats < 18) && cyc < 300) begin
      for (int r = 0; r < NR; r++) begin
        valid[r] = (sent[r] < 6);
        tid[r]   = 8'(r * 16 + sent[r]);
        data[r]  = 64'(r * 16 + sent[r]) + 64'h1000;
      end
      rdy = ready;
      for (int r = 0; r < NR; r++) begin
        total++;
        if (ready[r] !== (cnt_m[r] != 2)) begin
          bad++; $display("FAIL full_ready%0d: got %b expected %b at cycle %0d",
                          r, ready[r], (cnt_m[r] != 2), cyc);
        end
      end
      if (!ready[1]) saw_full = 1'b1;
      tick();
      cyc++;
      for (int r = 0; r < NR; r++) begin
        if (valid[r] && rdy[r]) begin
          sent[r]++; cnt_m[r]++;
        end
      end
      if (wt_valid) begin
        nbeats++;
        total++;
        if ($countones(grant) != 1 || wbdata !== 64'(tid_o) + 64'h1000) begin
          bad++; $display("FAIL full_beat: got g=%b id=%h d=%h expected one-hot/d=id+1000",
                          grant, tid_o, wbdata);
        end
        for (int r = 0; r < NR; r++) begin
          if (grant[r]) begin
            cnt_m[r]--;
            got[r].push_back(tid_o);
          end
        end
      end
    end
    clear_inputs();
    total++;
    if (cyc >= 300) begin
      bad++; $display("FAIL full_timeout: got %0d beats expected 18", nbeats);
    end
    total++;
    if (!saw_full) begin
      bad++; $display("FAIL full_ready_drop: got ready[1] always 1 expected a drop");
    end
    for (int r = 0; r < NR; r++) begin
      total++;
      if (got[r].size() != 6) begin
        bad++; $display("FAIL full_count%0d: got %0d expected 6", r, got[r].size());
      end else begin
        for (int k = 0; k < 6; k++) begin
          total++;
          if (got[r][k] !== 8'(r * 16 + k)) begin
            bad++; $display("FAIL full_order%0d_%0d: got %h expected %h", r, k, got[r][k], 8'(r * 16 + k));
          end
        end
      end
    end
    nbeats = 0;
    repeat (3) begin
      tick();
      if (wt_valid) nbeats++;
    end
    total++;
    if (nbeats != 0) begin
      bad++; $display("FAIL full_extra: got %0d beats expected 0", nbeats);
    end
  endtask

  task automatic test_perf();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if (conflict_cnt !== 32'd0) begin
      bad++; $display("FAIL perf_reset: got %0d expected 0", conflict_cnt);
    end
    valid = 3'b011; tid = {8'h0, 8'h51, 8'h50};
    tick();
    tid = {8'h0, 8'h53, 8'h52};
    tick();
    valid = 3'b001; tid[0] = 8'h54;
    tick();
    clear_inputs();
    total++;
    if (conflict_cnt !== EXP_C2) begin
      bad++; $display("FAIL perf_mid: got %0d expected %0d", conflict_cnt, EXP_C2);
    end
    repeat (4) tick();
    total++;
    if (conflict_cnt !== EXP_C4) begin
      bad++; $display("FAIL perf_final: got %0d expected %0d", conflict_cnt, EXP_C4);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    total++;
    if (conflict_cnt !== EXP_C4) begin
      bad++; $display("FAIL perf_flush: got %0d expected %0d", conflict_cnt, EXP_C4);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid();
    test_round_robin();
    test_exception();
    test_back_to_back();
    test_flush();
    test_full_fifo();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
